lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
Downstream consumer of the LSU's LCD output register (o_io_lcd). It turns a software "write" request into an HD44780-compliant bus transaction on the physical character LCD, enforcing setup, enable-pulse, hold and execution timing in hardware. It also provides a one-deep request buffer, a busy flag and a sticky overrun flag. Same clock domain as the LSU, and the input is already registered, so no synchroniser is required.

Parameters:
T_SETUP_CYC, 4, cycles with RS/DATA stable before EN rises (80 ns @50 MHz)
T_EN_CYC, 25, cycles EN held high (500 ns)
T_HOLD_CYC, 2, cycles RS/DATA held after EN falls
T_EXEC_CYC, 2500, post-pulse wait for normal commands/data (50 us)
T_EXEC_LONG_CYC, 82000, post-pulse wait for clear/home (1.64 ms)
CNT_W, 17, timer width; must hold max(all T_*) - 1

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_io_lcd  in  32  LSU LCD register: [31] ON, [11] CLR_OVR, [10] REQ, [9] RS, [7:0] DATA; other bits ignored
o_lcd_on  out  1  LCD power/backlight
o_lcd_en  out  1  LCD EN
o_lcd_rs  out  1  LCD RS
o_lcd_rw  out  1  LCD RW, constant 0 (write-only)
o_lcd_data  out  8  LCD DB[7:0]
o_busy  out  1  transaction active or request pending
o_overrun  out  1  sticky: a request was dropped

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; pending slot empty; prev_req=0; timer=0.
- o_lcd_on is i_io_lcd[31] registered, giving 1-cycle latency.
- Request detection:
  - A request is i_io_lcd[10] & ~prev_req, evaluated combinationally each cycle.
  - prev_req is updated every edge.
  - Holding REQ high produces exactly one request.
  - If REQ is already high out of reset, no request occurs until REQ falls and rises again.
- Capture: a request carries {RS=i_io_lcd[9], DATA=i_io_lcd[7:0]} sampled in the request cycle.
- Long command: RS==0 and DATA in {0x01, 0x02, 0x03}. EXEC then uses T_EXEC_LONG_CYC; every other command uses T_EXEC_CYC.
- FSM states:
  - IDLE: EN=0. On request, load active {rs,data,long}, load timer, go to SETUP.
  - SETUP: EN=0, RS/DATA driven. Lasts T_SETUP_CYC cycles, then PULSE.
  - PULSE: EN=1. Lasts T_EN_CYC cycles, then HOLD.
  - HOLD: EN=0. Lasts T_HOLD_CYC cycles, then EXEC.
  - EXEC: EN=0. Lasts T_EXEC_CYC or T_EXEC_LONG_CYC cycles. At the end:
    - pending valid: move pending to active, go to SETUP (no IDLE cycle);
    - pending empty: go to IDLE.
- Timer: a single down-counter loaded with T_x-1 on entry to each state. The state advances when it reaches 0.
- o_lcd_rs and o_lcd_data are registered from the active slot. They hold their last value after the transaction and through IDLE.
- o_busy = (state != IDLE) | pending_valid. It rises the cycle after the request.
- Total busy time for an isolated request = T_SETUP + T_EN + T_HOLD + T_EXEC(_LONG) cycles.
- Request while not IDLE:
  - pending empty: capture into pending.
  - pending full: drop the request and set o_overrun.
- Simultaneous request and EXEC completion:
  - pending empty: the new request goes directly to active, then SETUP.
  - pending full: pending goes to active, the new request goes to pending, no overrun.
- o_overrun clears while i_io_lcd[11]==1. If a drop and CLR_OVR occur in the same cycle, set wins.
- Reset mid-transaction: EN falls immediately (asynchronous). The transaction and pending slot are discarded; no partial completion.

Decomposition:
- Shared package lcd_pkg:
  - state enum {IDLE, SETUP, PULSE, HOLD, EXEC};
  - bit-index constants LCD_ON_BIT=31, LCD_CLR_OVR_BIT=11, LCD_REQ_BIT=10, LCD_RS_BIT=9, LCD_DATA_MSB=7;
  - long-command codes 8'h01, 8'h02, 8'h03;
  - default timing constants.
- Single module; no sub-module is warranted (timer, edge detect and pending slot are each a few lines).

Test Plan:
Bench parameters for all scenarios: T_SETUP=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20.
1. Reset with i_io_lcd=32'hFFFF_FFFF -> all outputs 0; after release, o_lcd_on=1 one cycle later and no transaction starts (REQ already high).
2. Request RS=1, DATA=8'h41 -> o_lcd_rs=1 and o_lcd_data=8'h41 from the next cycle; EN high for exactly 3 cycles starting 2 cycles after SETUP entry; o_busy high for exactly 11 cycles; o_lcd_rw always 0.
3. Request RS=0, DATA=8'h01 -> o_busy high 26 cycles. Request RS=1, DATA=8'h01 -> o_busy high 11 cycles (not long).
4. Three requests (0x30, 0x31, 0x32) issued during the first transaction's PULSE -> 0x30 and 0x31 each produce exactly one EN pulse, in order, with no IDLE gap; 0x32 is never driven; o_overrun=1; REQ with bit 11 set -> o_overrun=0.
5. Hold REQ high for 100 cycles -> exactly one EN pulse. New request on the exact cycle EXEC ends with pending empty -> SETUP entered with no IDLE cycle.
6. Assert i_rst mid-PULSE -> o_lcd_en drops without waiting for a clock edge; o_busy=0; the pending request is lost; no EN pulse after reset is released.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD write controller:
// FSM states, LSU register bit positions, long-command codes and
// default bus timing at 50 MHz.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      EXEC
   } lcd_state_t;

   // Bit positions inside the LSU LCD output register
   localparam int LCD_ON_BIT      = 31;
   localparam int LCD_CLR_OVR_BIT = 11;
   localparam int LCD_REQ_BIT     = 10;
   localparam int LCD_RS_BIT      = 9;
   localparam int LCD_DATA_MSB    = 7;

   // Instructions that need the long execution time (clear / return home)
   localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
   localparam logic [7:0] LCD_CMD_HOME_ALT  = 8'h03;

   // Default timing in clock cycles at 50 MHz
   localparam int DEF_T_SETUP_CYC     = 4;
   localparam int DEF_T_EN_CYC        = 25;
   localparam int DEF_T_HOLD_CYC      = 2;
   localparam int DEF_T_EXEC_CYC      = 2500;
   localparam int DEF_T_EXEC_LONG_CYC = 82000;
   localparam int DEF_CNT_W           = 17;

   // An instruction (RS=0) of clear or home needs the long execution wait
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) &&
             ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) ||
              (data == LCD_CMD_HOME_ALT));
   endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus controller. Turns a rising edge of the REQ bit in
// the LSU LCD register into a timed SETUP / EN PULSE / HOLD / EXEC bus cycle,
// with a one-deep pending slot, a busy flag and a sticky overrun flag.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_SETUP_CYC     = DEF_T_SETUP_CYC,
   parameter int T_EN_CYC        = DEF_T_EN_CYC,
   parameter int T_HOLD_CYC      = DEF_T_HOLD_CYC,
   parameter int T_EXEC_CYC      = DEF_T_EXEC_CYC,
   parameter int T_EXEC_LONG_CYC = DEF_T_EXEC_LONG_CYC,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_io_lcd,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data,
   output logic        o_busy,
   output logic        o_overrun
);

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG_CYC - 1);

   lcd_state_t       state, state_next;
   logic [CNT_W-1:0] timer, timer_next;
   logic             act_rs, act_rs_next;
   logic [7:0]       act_data, act_data_next;
   logic             act_long, act_long_next;
   logic             pend_valid, pend_valid_next;
   logic             pend_rs, pend_rs_next;
   logic [7:0]       pend_data, pend_data_next;
   logic             pend_long, pend_long_next;
   logic             overrun, overrun_next;
   logic             prev_req;
   logic             armed;
   logic             lcd_on;

   logic             req;
   logic             new_rs;
   logic [7:0]       new_data;
   logic             new_long;
   logic             exec_done;
   logic             drop;
   logic             unused_bits;

   assign unused_bits = ^{i_io_lcd[30:12], i_io_lcd[8]};

   // armed is low for the first edge after reset, so a REQ that is already
   // high when reset releases is treated as old and needs a fresh rising edge.
   assign req       = i_io_lcd[LCD_REQ_BIT] & ~prev_req & armed;
   assign new_rs    = i_io_lcd[LCD_RS_BIT];
   assign new_data  = i_io_lcd[LCD_DATA_MSB:0];
   assign new_long  = is_long_cmd(new_rs, new_data);
   assign exec_done = (state == EXEC) && (timer == '0);

   // Register all state; async reset discards any transaction in flight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         timer      <= '0;
         act_rs     <= 1'b0;
         act_data   <= '0;
         act_long   <= 1'b0;
         pend_valid <= 1'b0;
         pend_rs    <= 1'b0;
         pend_data  <= '0;
         pend_long  <= 1'b0;
         overrun    <= 1'b0;
         prev_req   <= 1'b0;
         armed      <= 1'b0;
         lcd_on     <= 1'b0;
      end else begin
         state      <= state_next;
         timer      <= timer_next;
         act_rs     <= act_rs_next;
         act_data   <= act_data_next;
         act_long   <= act_long_next;
         pend_valid <= pend_valid_next;
         pend_rs    <= pend_rs_next;
         pend_data  <= pend_data_next;
         pend_long  <= pend_long_next;
         overrun    <= overrun_next;
         prev_req   <= i_io_lcd[LCD_REQ_BIT];
         armed      <= 1'b1;
         lcd_on     <= i_io_lcd[LCD_ON_BIT];
      end
   end

   // Next-state, timer, active/pending slot and overrun logic
   always_comb begin
      state_next      = state;
      timer_next      = timer;
      act_rs_next     = act_rs;
      act_data_next   = act_data;
      act_long_next   = act_long;
      pend_valid_next = pend_valid;
      pend_rs_next    = pend_rs;
      pend_data_next  = pend_data;
      pend_long_next  = pend_long;
      drop            = 1'b0;

      case (state)
         IDLE: begin
            if (req) begin
               act_rs_next   = new_rs;
               act_data_next = new_data;
               act_long_next = new_long;
               timer_next    = LD_SETUP;
               state_next    = SETUP;
            end
         end
         SETUP: begin
            if (timer == '0) begin
               timer_next = LD_EN;
               state_next = PULSE;
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         PULSE: begin
            if (timer == '0) begin
               timer_next = LD_HOLD;
               state_next = HOLD;
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         HOLD: begin
            if (timer == '0) begin
               timer_next = act_long ? LD_LONG : LD_EXEC;
               state_next = EXEC;
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         EXEC: begin
            if (timer == '0) begin
               if (pend_valid) begin
                  // Pending goes active; a coincident request refills the slot
                  act_rs_next     = pend_rs;
                  act_data_next   = pend_data;
                  act_long_next   = pend_long;
                  pend_valid_next = req;
                  if (req) begin
                     pend_rs_next   = new_rs;
                     pend_data_next = new_data;
                     pend_long_next = new_long;
                  end
                  timer_next = LD_SETUP;
                  state_next = SETUP;
               end else if (req) begin
                  act_rs_next   = new_rs;
                  act_data_next = new_data;
                  act_long_next = new_long;
                  timer_next    = LD_SETUP;
                  state_next    = SETUP;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A request mid-transaction is buffered once, further ones are dropped
      if (req && (state != IDLE) && !exec_done) begin
         if (!pend_valid) begin
            pend_valid_next = 1'b1;
            pend_rs_next    = new_rs;
            pend_data_next  = new_data;
            pend_long_next  = new_long;
         end else begin
            drop = 1'b1;
         end
      end

      // Set beats clear when both happen in the same cycle
      if (drop) begin
         overrun_next = 1'b1;
      end else if (i_io_lcd[LCD_CLR_OVR_BIT]) begin
         overrun_next = 1'b0;
      end else begin
         overrun_next = overrun;
      end
   end

   // EN decoded from the async-reset state so it falls as soon as reset rises
   assign o_lcd_en   = (state == PULSE);
   assign o_lcd_rs   = act_rs;
   assign o_lcd_data = act_data;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_on   = lcd_on;
   assign o_overrun  = overrun;
   assign o_busy     = (state != IDLE) | pend_valid;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl using shortened timing. A transaction-level
// model (elapsed-time schedule plus a command queue) predicts every output
// each cycle; table vectors and hand sequences add targeted checks.
module tb_lcd_ctrl;

   localparam int TS  = 2;
   localparam int TE  = 3;
   localparam int TH  = 1;
   localparam int TX  = 5;
   localparam int TXL = 20;

   logic        clk;
   logic        rst;
   logic [31:0] io;
   logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, overrun;
   logic [7:0]  lcd_data;

   lcd_ctrl #(
      .T_SETUP_CYC(TS), .T_EN_CYC(TE), .T_HOLD_CYC(TH),
      .T_EXEC_CYC(TX), .T_EXEC_LONG_CYC(TXL), .CNT_W(17)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_io_lcd(io),
      .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs),
      .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data), .o_busy(busy),
      .o_overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic       rs;
      logic [7:0] data;
   } cmd_t;

   cmd_t       m_q[$];
   cmd_t       m_act;
   logic       m_valid;
   int         m_el;
   logic       m_ovr;
   logic       m_prev;
   logic       m_on;

   function automatic int dur_of(input cmd_t c);
      logic lng;
      lng = (c.rs == 1'b0) && (c.data >= 8'h01) && (c.data <= 8'h03);
      return TS + TE + TH + (lng ? TXL : TX);
   endfunction

   // After reset a request needs REQ to be observed low first
   task automatic model_reset();
      m_q.delete();
      m_act.rs   = 1'b0;
      m_act.data = 8'h00;
      m_valid    = 1'b0;
      m_el       = 0;
      m_ovr      = 1'b0;
      m_prev     = 1'b1;
      m_on       = 1'b0;
   endtask

   task automatic model_edge(input logic [31:0] v);
      logic req, ending, drop;
      cmd_t c;
      req    = v[10] & ~m_prev;
      m_prev = v[10];
      m_on   = v[31];
      c.rs   = v[9];
      c.data = v[7:0];
      drop   = 1'b0;
      ending = m_valid && (m_el == dur_of(m_act) - 1);
      if (m_valid && !ending) begin
         m_el++;
         if (req) begin
            if (m_q.size() == 0) m_q.push_back(c);
            else drop = 1'b1;
         end
      end else begin
         if (req) m_q.push_back(c);
         if (m_q.size() > 0) begin
            m_act   = m_q.pop_front();
            m_valid = 1'b1;
            m_el    = 0;
         end else begin
            m_valid = 1'b0;
         end
      end
      if (drop) m_ovr = 1'b1;
      else if (v[11]) m_ovr = 1'b0;
   endtask

   // ---------------- observation / checking ----------------
   int   en_pulses = 0;
   logic prev_en   = 1'b0;
   logic [7:0] en_log[$];
   int   run_cur   = 0;
   int   run_last  = 0;

   task automatic check_cycle();
      logic e_en, e_busy;
      e_en   = m_valid && (m_el >= TS) && (m_el < TS + TE);
      e_busy = m_valid || (m_q.size() > 0);
      n_vec++;
      if (lcd_en !== e_en || lcd_rs !== m_act.rs || lcd_data !== m_act.data ||
          busy !== e_busy || overrun !== m_ovr || lcd_on !== m_on || lcd_rw !== 1'b0) begin
         n_bad++;
         $display("FAIL cycle t=%0t: got en=%b rs=%b data=%h busy=%b ovr=%b on=%b rw=%b, want en=%b rs=%b data=%h busy=%b ovr=%b on=%b rw=0",
                  $time, lcd_en, lcd_rs, lcd_data, busy, overrun, lcd_on, lcd_rw,
                  e_en, m_act.rs, m_act.data, e_busy, m_ovr, m_on);
      end
      if (lcd_en && !prev_en) begin
         en_pulses++;
         en_log.push_back(lcd_data);
      end
      prev_en = lcd_en;
      if (busy) run_cur++;
      else if (run_cur != 0) begin
         run_last = run_cur;
         run_cur  = 0;
      end
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic step(input logic [31:0] v);
      io = v;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(v);
      #1;
      check_cycle();
   endtask

   function automatic logic [31:0] mk(input logic on, input logic clr, input logic rq,
                                      input logic rs, input logic [7:0] d);
      logic [31:0] v;
      v     = 32'h0;
      v[31] = on;
      v[11] = clr;
      v[10] = rq;
      v[9]  = rs;
      v[7:0] = d;
      return v;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (busy && n < 300) begin
         step(32'h0);
         n++;
      end
      if (busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain-timeout: busy still %b after %0d cycles, want 0", busy, n);
      end
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         exp_busy;
      int         exp_en;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [31:0] v;
      int p0;
      logic lvl;

      tbl[0] = '{1'b1, 8'h41, 11, 3};
      tbl[1] = '{1'b0, 8'h01, 26, 3};
      tbl[2] = '{1'b1, 8'h01, 11, 3};
      tbl[3] = '{1'b0, 8'h02, 26, 3};
      tbl[4] = '{1'b0, 8'h03, 26, 3};
      tbl[5] = '{1'b0, 8'h04, 11, 3};
      tbl[6] = '{1'b0, 8'h00, 11, 3};
      tbl[7] = '{1'b1, 8'h02, 11, 3};

      // Reset with every input bit high
      rst = 1'b1;
      io  = 32'hFFFF_FFFF;
      model_reset();
      #1;
      check_cycle();
      repeat (3) step(32'hFFFF_FFFF);
      expect_int("reset_en", int'(lcd_en), 0);
      expect_int("reset_on", int'(lcd_on), 0);
      rst = 1'b0;
      step(32'hFFFF_FFFF);
      expect_int("on_after_release", int'(lcd_on), 1);
      expect_int("no_req_out_of_reset", int'(busy), 0);
      repeat (3) step(32'hFFFF_FFFF);
      expect_int("still_idle_req_held", int'(busy), 0);
      step(32'h0);
      step(32'h0);
      $display("reset: on=%b busy=%b en=%b", lcd_on, busy, lcd_en);

      // Table-driven single transactions
      for (int i = 0; i < 8; i++) begin
         en_log.delete();
         p0 = en_pulses;
         step(mk(1'b1, 1'b0, 1'b1, tbl[i].rs, tbl[i].data));
         expect_int("busy_rise", int'(busy), 1);
         expect_int("rs_next_cycle", int'(lcd_rs), int'(tbl[i].rs));
         expect_int("data_next_cycle", int'(lcd_data), int'(tbl[i].data));
         drain();
         expect_int("busy_len", run_last, tbl[i].exp_busy);
         expect_int("en_pulses", en_pulses - p0, tbl[i].exp_en == 3 ? 1 : 0);
         expect_int("rs_holds", int'(lcd_rs), int'(tbl[i].rs));
         $display("vec %0d: rs=%b data=%h busy_len=%0d pulses=%0d", i, tbl[i].rs,
                  tbl[i].data, run_last, en_pulses - p0);
      end

      // EN width: exactly 3 high cycles starting 2 cycles after SETUP entry
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h55));
      begin
         int hi;
         int first;
         hi = 0;
         first = -1;
         for (int k = 1; k < 11; k++) begin
            if (lcd_en && first < 0) first = k - 1;
            if (lcd_en) hi++;
            step(32'h0);
         end
         expect_int("en_width", hi, TE);
         expect_int("en_start", first, TS);
      end
      drain();

      // Two buffered, one dropped, then clear overrun
      en_log.delete();
      p0 = en_pulses;
      step(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h30));
      step(32'h0);
      step(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h31));
      step(32'h0);
      step(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h32));
      drain();
      expect_int("queue_pulses", en_pulses - p0, 2);
      expect_int("queue_first", en_log.size() > 0 ? int'(en_log[0]) : -1, 'h30);
      expect_int("queue_second", en_log.size() > 1 ? int'(en_log[1]) : -1, 'h31);
      expect_int("no_idle_gap", run_last, 22);
      expect_int("overrun_set", int'(overrun), 1);
      step(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h33));
      expect_int("overrun_cleared", int'(overrun), 0);
      drain();
      $display("queue: pulses=%0d run=%0d", en_pulses - p0, run_last);

      // REQ held high for 100 cycles gives exactly one pulse
      p0 = en_pulses;
      repeat (100) step(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h7A));
      step(32'h0);
      drain();
      expect_int("held_req_pulses", en_pulses - p0, 1);
      $display("held req: pulses=%0d", en_pulses - p0);

      // Request on the exact last EXEC cycle with pending empty
      p0 = en_pulses;
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h60));
      repeat (TS + TE + TH + TX - 1) step(32'h0);
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h61));
      expect_int("back_to_back_busy", int'(busy), 1);
      drain();
      expect_int("back_to_back_run", run_last, 22);
      expect_int("back_to_back_pulses", en_pulses - p0, 2);
      $display("exec-end req: run=%0d pulses=%0d", run_last, en_pulses - p0);

      // Async reset mid-PULSE with a pending request
      p0 = en_pulses;
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h50));
      step(32'h0);
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h51));
      expect_int("in_pulse", int'(lcd_en), 1);
      #2 rst = 1'b1;
      #1;
      expect_int("async_en_drop", int'(lcd_en), 0);
      expect_int("async_busy_drop", int'(busy), 0);
      model_reset();
      prev_en = 1'b0;
      step(32'h0);
      step(32'h0);
      rst = 1'b0;
      p0 = en_pulses;
      repeat (40) step(32'h0);
      expect_int("no_pulse_after_reset", en_pulses - p0, 0);
      $display("async reset: pulses after release=%0d", en_pulses - p0);

      // Randomized traffic against the model
      lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) == 0) lvl = ~lvl;
         v = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), lvl,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom));
         step(v);
      end
      step(32'h0);
      drain();
      $display("random: %0d pulses total", en_pulses);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
